// File: rtl/counter_defs_pkg.sv
// Shared counter encodings.
// Direction and bound-mode encodings used by every counting primitive
// in the codebase, so a stage driven by another block agrees on meaning.
package counter_defs_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_next_calc.sv
// Next-count calculator (purely combinational).
// Computes the value the counter takes if it counts this edge, and
// flags when the current value sits on the bound in the chosen direction.
//   q         : current count
//   up_dn     : direction (DIR_UP / DIR_DN)
//   sat_mode  : MODE_WRAP or MODE_SAT behaviour at the bound
//   next_q    : count after one step
//   bound_hit : q is at MAX_VAL going up, or at 0 going down
module counter_next_calc
  import counter_defs_pkg::*;
#(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   MAX_VAL = '1
) (
  input  logic [N-1:0] q,
  input  logic         up_dn,
  input  logic         sat_mode,
  output logic [N-1:0] next_q,
  output logic         bound_hit
);

  // Bounds are detected by compare against MAX_VAL rather than by N-bit
  // overflow, so non-power-of-two moduli wrap exactly.
  always_comb begin
    next_q    = q;
    bound_hit = 1'b0;
    case (up_dn)
      DIR_UP: begin
        if (q == MAX_VAL) begin
          bound_hit = 1'b1;
          next_q    = (sat_mode == MODE_WRAP) ? '0 : MAX_VAL;
        end else begin
          next_q = q + N'(1);
        end
      end
      DIR_DN: begin
        if (q == '0) begin
          bound_hit = 1'b1;
          next_q    = (sat_mode == MODE_WRAP) ? MAX_VAL : '0;
        end else begin
          next_q = q - N'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with programmable terminal
// value, parallel load, synchronous clear, wrap/saturate mode, a
// combinational terminal-count output and a sticky overflow flag.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (q=0, ovf=0)
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val, clamped to MAX_VAL
//   load_val : value to load
//   en       : count enable (lowest priority)
//   up_dn    : 1 = up, 0 = down
//   sat_mode : 0 = wrap, 1 = saturate at the bounds
//   q        : registered count, range 0..MAX_VAL
//   tc       : counting this edge and q is at the bound in current direction
//   ovf      : sticky; set when a bound is crossed or a crossing is blocked
module sync_updown_counter #(
  parameter int unsigned N       = 4,
  parameter int unsigned MAX_VAL = 2**N - 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up_dn,
  input  logic         sat_mode,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf
);

  localparam logic [N-1:0] MAX_Q = N'(MAX_VAL);

  logic [N-1:0] next_q;
  logic         bound_hit;
  logic [N-1:0] load_q;

  counter_next_calc #(
    .N       (N),
    .MAX_VAL (MAX_Q)
  ) u_next (
    .q         (q),
    .up_dn     (up_dn),
    .sat_mode  (sat_mode),
    .next_q    (next_q),
    .bound_hit (bound_hit)
  );

  assign load_q = (load_val > MAX_Q) ? MAX_Q : load_val;

  // tc is only meaningful when this edge will actually count, so it is
  // masked by the higher-priority clr/load; a cascaded stage can use it
  // directly as its enable.
  assign tc = en & ~clr & ~load & bound_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= load_q;
    end else if (en) begin
      q <= next_q;
      if (bound_hit) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q_o [2];
  logic [1:0] tc_o;
  logic [1:0] ovf_o;

  int checks = 0;
  int failures = 0;

  // reference state: instance 0 is a decade counter, instance 1 full range
  int mx [2] = '{9, 15};
  int m_q [2];
  int m_ovf [2];

  always #5 clk = ~clk;

  sync_updown_counter #(.N(4), .MAX_VAL(9)) u_dec (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  sync_updown_counter #(.N(4)) u_full (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  function automatic logic tc_exp(int i);
    if (!en || clr || load) return 1'b0;
    return up_dn ? (m_q[i] == mx[i]) : (m_q[i] == 0);
  endfunction

  // one clock edge of the behavioural model, written as range arithmetic
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_q[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_q[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
      end else if (en) begin
        int nq;
        nq = up_dn ? m_q[i] + 1 : m_q[i] - 1;
        if (nq < 0 || nq > mx[i]) begin
          m_ovf[i] = 1;
          if (sat_mode) m_q[i] = (nq < 0) ? 0 : mx[i];
          else          m_q[i] = (nq + mx[i] + 1) % (mx[i] + 1);
        end else begin
          m_q[i] = nq;
        end
      end
    end
  endtask

  task automatic drive(input logic c, input logic l, input int lv,
                       input logic e, input logic u, input logic s);
    clr = c; load = l; load_val = 4'(lv); en = e; up_dn = u; sat_mode = s;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk); @(posedge clk); #1;
    m_q = '{0, 0}; m_ovf = '{0, 0};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q_o[i] !== 4'd0 || ovf_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d: q=%0d ovf=%b tc=%b, required q=0 ovf=0 tc=0",
                 i, q_o[i], ovf_o[i], tc_o[i]);
      end
    end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 1, 1, 0);
      checks++;
      if (tc_o[0] !== (m_q[0] == 9) || tc_o[1] !== tc_exp(1)) begin
        failures++;
        $display("FAIL up_wrap tc k=%0d: tc=%b, required %b%b", k, tc_o, tc_exp(1), m_q[0] == 9);
      end
      step();
      checks++;
      if (q_o[0] !== 4'((k + 1) % 10) || ovf_o[0] !== (k >= 9)) begin
        failures++;
        $display("FAIL up_wrap dec k=%0d: q=%0d ovf=%b, required q=%0d ovf=%b",
                 k, q_o[0], ovf_o[0], (k + 1) % 10, k >= 9);
      end
      checks++;
      if (q_o[1] !== 4'(m_q[1]) || ovf_o[1] !== 1'(m_ovf[1])) begin
        failures++;
        $display("FAIL up_wrap full k=%0d: q=%0d ovf=%b, required q=%0d ovf=%0d",
                 k, q_o[1], ovf_o[1], m_q[1], m_ovf[1]);
      end
    end
  endtask

  task automatic test_down_sat();
    int exp_q [4] = '{1, 0, 0, 0};
    int exp_o [4] = '{0, 0, 1, 1};
    drive(1, 0, 0, 0, 1, 0); step();
    drive(0, 1, 2, 0, 0, 1); step();
    checks++;
    if (q_o[0] !== 4'd2 || q_o[1] !== 4'd2) begin
      failures++;
      $display("FAIL down_sat load: q=%0d/%0d, required 2/2", q_o[0], q_o[1]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0, 1);
      checks++;
      if (tc_o !== {tc_exp(1), tc_exp(0)}) begin
        failures++;
        $display("FAIL down_sat tc k=%0d: tc=%b, required %b%b", k, tc_o, tc_exp(1), tc_exp(0));
      end
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_o[i] !== 4'(exp_q[k]) || ovf_o[i] !== 1'(exp_o[k])) begin
          failures++;
          $display("FAIL down_sat inst%0d k=%0d: q=%0d ovf=%b, required q=%0d ovf=%0d",
                   i, k, q_o[i], ovf_o[i], exp_q[k], exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 13, 0, 1, 0);
    checks++;
    if (tc_o !== 2'b00) begin
      failures++; $display("FAIL load tc: tc=%b, required 00", tc_o);
    end
    step();
    checks++;
    if (q_o[0] !== 4'd9 || q_o[1] !== 4'd13) begin
      failures++; $display("FAIL load_clamp: q=%0d/%0d, required 9/13", q_o[0], q_o[1]);
    end
    drive(1, 1, 7, 1, 1, 0); step();
    checks++;
    if (q_o[0] !== 4'd0 || ovf_o !== 2'b00 || q_o[1] !== 4'd0) begin
      failures++;
      $display("FAIL clr_wins: q=%0d/%0d ovf=%b, required 0/0 ovf=00", q_o[0], q_o[1], ovf_o);
    end
    drive(0, 1, 5, 1, 1, 0); step();
    checks++;
    if (q_o[0] !== 4'd5 || q_o[1] !== 4'd5) begin
      failures++; $display("FAIL load_wins: q=%0d/%0d, required 5/5", q_o[0], q_o[1]);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();   // down-wrap sets ovf
    drive(0, 1, 0, 0, 1, 0); step();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 1, 1, 0); step();
    end
    checks++;
    if (q_o[0] !== 4'd6 || ovf_o !== 2'b11) begin
      failures++; $display("FAIL async_pre: q=%0d ovf=%b, required q=6 ovf=11", q_o[0], ovf_o);
    end
    #3 reset_n = 1'b0;
    #1;
    m_q = '{0, 0}; m_ovf = '{0, 0};
    checks++;
    if (q_o[0] !== 4'd0 || q_o[1] !== 4'd0 || ovf_o !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: q=%0d/%0d ovf=%b, required 0/0 ovf=00", q_o[0], q_o[1], ovf_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q_o[0] !== 4'd0 || q_o[1] !== 4'd0) begin
        failures++; $display("FAIL async_hold k=%0d: q=%0d/%0d, required 0/0", k, q_o[0], q_o[1]);
      end
    end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_full_range();
    drive(1, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    checks++;
    if (q_o[1] !== 4'd15 || ovf_o[1] !== 1'b1 || q_o[0] !== 4'd9) begin
      failures++;
      $display("FAIL full_down_wrap: q=%0d ovf=%b dec=%0d, required q=15 ovf=1 dec=9",
               q_o[1], ovf_o[1], q_o[0]);
    end
    drive(0, 0, 0, 1, 1, 0);
    checks++;
    if (tc_o !== 2'b11) begin
      failures++; $display("FAIL full_tc: tc=%b, required 11", tc_o);
    end
    step();
    checks++;
    if (q_o[1] !== 4'd0 || q_o[0] !== 4'd0) begin
      failures++; $display("FAIL full_up_wrap: q=%0d/%0d, required 0/0", q_o[0], q_o[1]);
    end
  endtask

  task automatic test_enable_dir();
    int exp_q [4] = '{5, 4, 5, 4};
    drive(0, 1, 4, 0, 1, 0); step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 1'($urandom), 1'($urandom));
      step();
      checks++;
      if (q_o[0] !== 4'd4 || q_o[1] !== 4'd4 || tc_o !== 2'b00) begin
        failures++;
        $display("FAIL en_gate k=%0d: q=%0d/%0d tc=%b, required 4/4 tc=00", k, q_o[0], q_o[1], tc_o);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, (k % 2 == 0), 0);
      checks++;
      if (tc_o !== 2'b00) begin
        failures++; $display("FAIL dir_flip tc k=%0d: tc=%b, required 00", k, tc_o);
      end
      step();
      checks++;
      if (q_o[0] !== 4'(exp_q[k]) || q_o[1] !== 4'(exp_q[k])) begin
        failures++;
        $display("FAIL dir_flip k=%0d: q=%0d/%0d, required %0d", k, q_o[0], q_o[1], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (tc_o[i] !== tc_exp(i)) begin
          failures++;
          $display("FAIL random tc inst%0d k=%0d: tc=%b, required %b", i, k, tc_o[i], tc_exp(i));
        end
      end
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (q_o[i] !== 4'(m_q[i]) || ovf_o[i] !== 1'(m_ovf[i])) begin
          failures++;
          $display("FAIL random inst%0d k=%0d: q=%0d ovf=%b, required q=%0d ovf=%0d",
                   i, k, q_o[i], ovf_o[i], m_q[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_priority();
    test_async_reset();
    test_full_range();
    test_enable_dir();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
Parametrised synchronous up/down counter. It generalises the team's ripple up-counter with:
- a programmable terminal value
- count enable, direction control and parallel load
- synchronous clear
- wrap or saturate mode
- terminal-count and sticky overflow flags

All state changes occur on a single clock edge, with no ripple delay. It serves as the general-purpose counting primitive for timers, dividers and event counters.

Parameters:
N, 4, counter width in bits (N >= 2).
MAX_VAL, 2**N-1, terminal value; count range is 0..MAX_VAL inclusive (1 <= MAX_VAL <= 2**N-1).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear.
load  input  1  synchronous parallel load.
load_val  input  N  value loaded when load=1.
en  input  1  count enable.
up_dn  input  1  direction: 1 = up, 0 = down.
sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds.
q  output  N  current count (registered).
tc  output  1  terminal count: combinational; high when en=1, clr=0, load=0 and q is at the bound in the current direction (MAX_VAL going up, 0 going down).
ovf  output  1  sticky flag: a bound was crossed (wrap) or a crossing was blocked (saturate).

Behaviour:
- Reset: reset_n=0 forces q=0 and ovf=0 immediately, independent of clk. Release is synchronous to the next clk edge. Reset asserted mid-count aborts the count at once; nothing is retained.
- Per-edge priority is clr > load > en. With none asserted, q holds.
- clr=1: q <= 0 and ovf <= 0.
- load=1 (clr=0):
  - q <= load_val when load_val <= MAX_VAL, otherwise q <= MAX_VAL (clamped).
  - ovf is unchanged; load never sets ovf.
- en=1, up_dn=1:
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL, sat_mode=0: q <= 0 and ovf <= 1.
  - q == MAX_VAL, sat_mode=1: q holds at MAX_VAL and ovf <= 1.
- en=1, up_dn=0:
  - q > 0: q <= q-1.
  - q == 0, sat_mode=0: q <= MAX_VAL and ovf <= 1.
  - q == 0, sat_mode=1: q holds at 0 and ovf <= 1.
- Arithmetic is N bits with an explicit compare against MAX_VAL. Wrap to 0 or MAX_VAL is decided by compare, not by natural N-bit overflow. This makes non-power-of-two moduli (e.g. MAX_VAL=9, a decade counter) exact.
- Latency: q reflects an operation one edge after it is sampled. tc is combinational from q, en, up_dn, clr and load, so it is valid in the same cycle as the wrapping edge's setup. This allows tc to drive en of a cascaded stage.
- Changing up_dn or sat_mode takes effect on the next edge. There is no internal pipeline and no mode-switch hazard.
- Simultaneous clr and load: clr wins, so q=0 and ovf=0.
- Simultaneous load and en: load wins and no count occurs.

Decomposition:
- Shared constants file (counter_defs): direction encodings DIR_UP=1'b1 and DIR_DN=1'b0, and mode encodings MODE_WRAP=1'b0 and MODE_SAT=1'b1. Other counters reuse these.
- One natural sub-module: counter_next_calc, purely combinational. Inputs are q, up_dn, sat_mode and MAX_VAL. Outputs are next_q and bound_hit.
- The top level holds the q/ovf registers, the priority mux and the tc logic.

Test Plan:
1. Reset and up-wrap: N=4, MAX_VAL=9. Assert reset_n=0, then release. en=1, up_dn=1, sat_mode=0 for 12 edges -> q steps 0,1,..,9,0,1,2. tc=1 only while q=9. ovf=1 from the edge where 9->0.
2. Down-saturate: load_val=2 with load=1 for one edge, then en=1, up_dn=0, sat_mode=1 for 4 edges -> q 2,1,0,0,0. tc=1 while q=0. ovf rises on the first blocked edge.
3. Load clamp and priority: MAX_VAL=9. load=1, load_val=13 -> q=9. Then load=1, clr=1, en=1 together -> q=0, ovf=0. Then load=1, en=1, load_val=5 -> q=5, no increment.
4. Async reset mid-count: count up to q=6, then drive reset_n=0 between edges -> q=0 and ovf=0 before the next edge. Hold reset_n low across 3 edges -> q stays 0.
5. Full-range default: N=4, MAX_VAL=15, down-wrap from q=0 -> q=15 and ovf=1. Then up from 15 with sat_mode=0 -> q=0.
6. Enable gating and direction flip: en=0 for 5 edges -> q constant. Then flip up_dn every edge at q=4 with en=1 -> q 5,4,5,4. tc stays 0.
